// File: rtl/vlane_sequencer_if.sv
// Issue and beat handshake bundle between scalar issue, vlane_sequencer and the lane array.
// master = issue side plus lane consumer, slave = the sequencer.
interface vlane_sequencer_if #(
   parameter int VLEN   = 128,
   parameter int ELEN   = 32,
   parameter int NLANES = 4,
   parameter int NVREG  = 32
);
   localparam int BEW  = NLANES * ELEN / 8;
   localparam int BPR  = VLEN / (NLANES * ELEN);
   localparam int RW   = $clog2(NVREG);
   localparam int VLW  = $clog2(8 * VLEN / 8) + 1;
   localparam int OFFW = (BPR > 1) ? $clog2(BPR) : 1;

   logic            issue_valid;
   logic            issue_ready;
   logic [RW-1:0]   issue_vd;
   logic [RW-1:0]   issue_vs1;
   logic [RW-1:0]   issue_vs2;
   logic [1:0]      issue_sew;
   logic [1:0]      issue_lmul;
   logic [VLW-1:0]  issue_vl;
   logic            issue_vm;
   logic [VLEN-1:0] v0_mask;

   logic            beat_valid;
   logic            beat_ready;
   logic [RW-1:0]   beat_vd;
   logic [RW-1:0]   beat_vs1;
   logic [RW-1:0]   beat_vs2;
   logic [OFFW-1:0] beat_off;
   logic [BEW-1:0]  beat_be;
   logic            beat_last;

   logic            busy;
   logic            done;
   logic            illegal;

   modport master (
      output issue_valid, issue_vd, issue_vs1, issue_vs2, issue_sew, issue_lmul,
             issue_vl, issue_vm, v0_mask, beat_ready,
      input  issue_ready, beat_valid, beat_vd, beat_vs1, beat_vs2, beat_off,
             beat_be, beat_last, busy, done, illegal
   );

   modport slave (
      input  issue_valid, issue_vd, issue_vs1, issue_vs2, issue_sew, issue_lmul,
             issue_vl, issue_vm, v0_mask, beat_ready,
      output issue_ready, beat_valid, beat_vd, beat_vs1, beat_vs2, beat_off,
             beat_be, beat_last, busy, done, illegal
   );
endinterface

// File: rtl/vlane_sequencer.sv
// Strip-mines one vector instruction into NLANES-wide beats with tail and optional v0 masking.
// Define VLANE_SEQ_MASK_EN to honour issue_vm/v0_mask; otherwise every instruction is unmasked.
//
// state  | meaning
// S_IDLE | waiting for an instruction, issue_ready high
// S_RUN  | presenting beats, beat counter advances on beat_ready
// S_DONE | one-cycle completion pulse
module vlane_sequencer #(
   parameter int VLEN   = 128,
   parameter int ELEN   = 32,
   parameter int NLANES = 4,
   parameter int NVREG  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   vlane_sequencer_if.slave bus
);
   localparam int BEW  = NLANES * ELEN / 8;
   localparam int BPR  = VLEN / (NLANES * ELEN);
   localparam int RW   = $clog2(NVREG);
   localparam int VLW  = $clog2(8 * VLEN / 8) + 1;
   localparam int OFFW = (BPR > 1) ? $clog2(BPR) : 1;
   localparam int LBEW = $clog2(BEW);
   localparam int LBPR = $clog2(BPR);
   localparam int BW   = $clog2(8 * BPR) + 1;
   localparam int MIW  = $clog2(VLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [RW-1:0]  vd_q, vs1_q, vs2_q;
   logic [1:0]     sew_q;
   logic [VLW-1:0] vl_q;
   logic [BW-1:0]  nbeats_q;
   logic [BW-1:0]  b_q;
   logic           illegal_q;

   logic [VLW-1:0] vlmax_c;
   logic [VLW-1:0] vl_eff_c;
   logic [BW-1:0]  nbeats_c;
   int             epb_log_c;
   logic           bad_c;
   logic           accept;
   logic           take;
   logic           last_c;

   function automatic logic bad_group(input logic [RW-1:0] base, input logic [1:0] lmul);
      int b;
      int n;
      b = int'(base);
      n = 1 << lmul;
      return ((b % n) != 0) || ((b + n) > NVREG);
   endfunction

   // Element k of the beat sits in bytes [k<<sew +: 1<<sew]; byte j belongs to element j>>sew.
   function automatic logic [BEW-1:0] beat_bytes(
      input logic [BW-1:0]   b,
      input logic [1:0]      sew,
      input logic [VLW-1:0]  vl,
      input logic            msk_on,
      input logic [VLEN-1:0] msk
   );
      logic [BEW-1:0] be;
      int g;
      be = '0;
      for (int j = 0; j < BEW; j++) begin
         g = (int'(b) << (LBEW - int'(sew))) + (j >> sew);
         be[j] = (g < int'(vl)) && (!msk_on || ((g < VLEN) && msk[g[MIW-1:0]]));
      end
      return be;
   endfunction

   logic            masked_q;
   logic [VLEN-1:0] mask_q;

   always_comb begin
      vlmax_c   = VLW'((VLEN << bus.issue_lmul) >> (3 + int'(bus.issue_sew)));
      vl_eff_c  = (bus.issue_vl < vlmax_c) ? bus.issue_vl : vlmax_c;
      epb_log_c = LBEW - int'(bus.issue_sew);
      nbeats_c  = BW'((int'(vl_eff_c) + (1 << epb_log_c) - 1) >> epb_log_c);
      bad_c     = (bus.issue_sew == 2'b11)
                  || bad_group(bus.issue_vd, bus.issue_lmul)
                  || bad_group(bus.issue_vs1, bus.issue_lmul)
                  || bad_group(bus.issue_vs2, bus.issue_lmul);
   end

   assign accept = bus.issue_valid && (state_q == S_IDLE);
   assign take   = accept && !bad_c;
   assign last_c = (b_q == (nbeats_q - BW'(1)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         vd_q      <= '0;
         vs1_q     <= '0;
         vs2_q     <= '0;
         sew_q     <= '0;
         vl_q      <= '0;
         nbeats_q  <= '0;
         b_q       <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= accept && bad_c;
         if (take) begin
            vd_q     <= bus.issue_vd;
            vs1_q    <= bus.issue_vs1;
            vs2_q    <= bus.issue_vs2;
            sew_q    <= bus.issue_sew;
            vl_q     <= vl_eff_c;
            nbeats_q <= nbeats_c;
            b_q      <= '0;
         end else if ((state_q == S_RUN) && bus.beat_ready) begin
            b_q <= b_q + BW'(1);
         end
      end
   end

`ifdef VLANE_SEQ_MASK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         masked_q <= 1'b0;
         mask_q   <= '0;
      end else if (take) begin
         masked_q <= ~bus.issue_vm;
         mask_q   <= bus.v0_mask;
      end
   end
`else
   logic unused_mask;
   assign masked_q    = 1'b0;
   assign mask_q      = '0;
   assign unused_mask = ^{bus.issue_vm, bus.v0_mask};
`endif

   always_comb begin
      state_d         = state_q;
      bus.issue_ready = 1'b0;
      bus.beat_valid  = 1'b0;
      bus.busy        = 1'b0;
      bus.done        = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.issue_ready = 1'b1;
            if (take) begin
               state_d = (vl_eff_c == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            bus.beat_valid = 1'b1;
            bus.busy       = 1'b1;
            if (bus.beat_ready && last_c) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Beat fields are forced to zero outside RUN so idle and reset look clean to the lanes.
   always_comb begin
      bus.beat_vd   = '0;
      bus.beat_vs1  = '0;
      bus.beat_vs2  = '0;
      bus.beat_off  = '0;
      bus.beat_be   = '0;
      bus.beat_last = 1'b0;
      if (state_q == S_RUN) begin
         bus.beat_vd   = vd_q  + RW'(b_q >> LBPR);
         bus.beat_vs1  = vs1_q + RW'(b_q >> LBPR);
         bus.beat_vs2  = vs2_q + RW'(b_q >> LBPR);
         bus.beat_off  = OFFW'(b_q & BW'(BPR - 1));
         bus.beat_be   = beat_bytes(b_q, sew_q, vl_q, masked_q, mask_q);
         bus.beat_last = last_c;
      end
   end

   assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_vlane_sequencer.sv
// Directed bench for vlane_sequencer at default parameters (BPR=1, BEW=16).
module tb_vlane_sequencer;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   vlane_sequencer_if bus ();

   vlane_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one instruction for a single edge, then scrambles the issue fields.
   task automatic issue(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                        input logic [1:0] sew, input logic [1:0] lmul, input logic [7:0] vl,
                        input logic vm, input logic [127:0] mask);
      bus.issue_vd    = vd;
      bus.issue_vs1   = vs1;
      bus.issue_vs2   = vs2;
      bus.issue_sew   = sew;
      bus.issue_lmul  = lmul;
      bus.issue_vl    = vl;
      bus.issue_vm    = vm;
      bus.v0_mask     = mask;
      bus.issue_valid = 1'b1;
      tick();
      bus.issue_valid = 1'b0;
      bus.issue_vd    = 5'd31;
      bus.issue_vs1   = 5'd31;
      bus.issue_vs2   = 5'd31;
      bus.issue_sew   = 2'b11;
      bus.issue_lmul  = 2'b11;
      bus.issue_vl    = 8'd0;
      bus.issue_vm    = 1'b1;
      bus.v0_mask     = '1;
   endtask

   logic [4:0]  exp_vd  [3];
   logic [4:0]  exp_vs2 [3];
   logic [15:0] exp_be  [3];
   logic [15:0] mask_exp;

   initial begin
      errors = 0;
      checks = 0;
      rst_n           = 1'b0;
      bus.issue_valid = 1'b0;
      bus.issue_vd    = '0;
      bus.issue_vs1   = '0;
      bus.issue_vs2   = '0;
      bus.issue_sew   = '0;
      bus.issue_lmul  = '0;
      bus.issue_vl    = '0;
      bus.issue_vm    = 1'b1;
      bus.v0_mask     = '0;
      bus.beat_ready  = 1'b1;
      exp_vd  = '{5'd4, 5'd5, 5'd6};
      exp_vs2 = '{5'd8, 5'd9, 5'd10};
      exp_be  = '{16'hFFFF, 16'hFFFF, 16'h00FF};

      tick();
      tick();
      chk("rst_issue_ready", bus.issue_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_beat_valid", bus.beat_valid, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_illegal", bus.illegal, 0);
      chk("rst_beat_be", bus.beat_be, 0);
      rst_n = 1'b1;
      tick();

      // SEW=32 LMUL=1 vl=3 vd=2: single partial beat
      issue(5'd2, 5'd0, 5'd1, 2'b10, 2'b00, 8'd3, 1'b1, '0);
      chk("s1_valid", bus.beat_valid, 1);
      chk("s1_vd", bus.beat_vd, 2);
      chk("s1_vs2", bus.beat_vs2, 1);
      chk("s1_off", bus.beat_off, 0);
      chk("s1_be", bus.beat_be, 16'h0FFF);
      chk("s1_last", bus.beat_last, 1);
      chk("s1_ready_low", bus.issue_ready, 0);
      chk("s1_busy", bus.busy, 1);
      tick();
      chk("s1_done", bus.done, 1);
      chk("s1_valid_off", bus.beat_valid, 0);
      tick();
      chk("s1_done_clear", bus.done, 0);
      chk("s1_ready_back", bus.issue_ready, 1);

      // SEW=8 LMUL=4 vl=40: three beats, tail on the third
      issue(5'd4, 5'd0, 5'd8, 2'b00, 2'b10, 8'd40, 1'b1, '0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("s2_valid%0d", i), bus.beat_valid, 1);
         chk($sformatf("s2_vd%0d", i), bus.beat_vd, exp_vd[i]);
         chk($sformatf("s2_vs2_%0d", i), bus.beat_vs2, exp_vs2[i]);
         chk($sformatf("s2_be%0d", i), bus.beat_be, exp_be[i]);
         chk($sformatf("s2_last%0d", i), bus.beat_last, (i == 2) ? 1 : 0);
         tick();
      end
      chk("s2_done", bus.done, 1);
      tick();
      chk("s2_ready_back", bus.issue_ready, 1);

      // same instruction, beat 1 stalled for three cycles
      issue(5'd4, 5'd0, 5'd8, 2'b00, 2'b10, 8'd40, 1'b1, '0);
      chk("s3_b0_vd", bus.beat_vd, 4);
      tick();
      bus.beat_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("s3_hold_valid%0d", i), bus.beat_valid, 1);
         chk($sformatf("s3_hold_vd%0d", i), bus.beat_vd, 5);
         chk($sformatf("s3_hold_vs2_%0d", i), bus.beat_vs2, 9);
         chk($sformatf("s3_hold_be%0d", i), bus.beat_be, 16'hFFFF);
         chk($sformatf("s3_hold_last%0d", i), bus.beat_last, 0);
      end
      bus.beat_ready = 1'b1;
      tick();
      chk("s3_b2_vd", bus.beat_vd, 6);
      chk("s3_b2_be", bus.beat_be, 16'h00FF);
      chk("s3_b2_last", bus.beat_last, 1);
      tick();
      chk("s3_done", bus.done, 1);
      tick();

      // vl=0 completes without beats
      issue(5'd0, 5'd0, 5'd0, 2'b10, 2'b00, 8'd0, 1'b1, '0);
      chk("vl0_done", bus.done, 1);
      chk("vl0_valid", bus.beat_valid, 0);
      tick();
      chk("vl0_ready_back", bus.issue_ready, 1);
      chk("vl0_done_clear", bus.done, 0);

      // SEW=32 LMUL=2 vl=200 clamps to 8 elements
      issue(5'd2, 5'd0, 5'd4, 2'b10, 2'b01, 8'd200, 1'b1, '0);
      chk("clamp_vd0", bus.beat_vd, 2);
      chk("clamp_be0", bus.beat_be, 16'hFFFF);
      chk("clamp_last0", bus.beat_last, 0);
      tick();
      chk("clamp_vd1", bus.beat_vd, 3);
      chk("clamp_be1", bus.beat_be, 16'hFFFF);
      chk("clamp_last1", bus.beat_last, 1);
      tick();
      chk("clamp_done", bus.done, 1);
      tick();

      // illegal SEW
      issue(5'd0, 5'd0, 5'd0, 2'b11, 2'b00, 8'd4, 1'b1, '0);
      chk("sew11_illegal", bus.illegal, 1);
      chk("sew11_ready", bus.issue_ready, 1);
      chk("sew11_valid", bus.beat_valid, 0);
      chk("sew11_busy", bus.busy, 0);
      tick();
      chk("sew11_pulse_end", bus.illegal, 0);
      chk("sew11_no_done", bus.done, 0);

      // misaligned destination group
      issue(5'd3, 5'd0, 5'd0, 2'b10, 2'b01, 8'd4, 1'b1, '0);
      chk("lmul_vd_illegal", bus.illegal, 1);
      chk("lmul_vd_valid", bus.beat_valid, 0);
      tick();
      chk("lmul_vd_pulse_end", bus.illegal, 0);

      // misaligned source group
      issue(5'd0, 5'd2, 5'd0, 2'b00, 2'b10, 8'd4, 1'b1, '0);
      chk("lmul_vs1_illegal", bus.illegal, 1);
      tick();

      // reset in the middle of an instruction
      issue(5'd4, 5'd0, 5'd8, 2'b00, 2'b10, 8'd40, 1'b1, '0);
      tick();
      chk("mid_b1_vd", bus.beat_vd, 5);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", bus.beat_valid, 0);
      chk("mid_rst_ready", bus.issue_ready, 1);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_vd", bus.beat_vd, 0);
      chk("mid_rst_be", bus.beat_be, 0);
      rst_n = 1'b1;
      tick();
      chk("mid_after_done", bus.done, 0);
      chk("mid_after_ready", bus.issue_ready, 1);

      // v0 masking: elements 1 and 3 enabled when the mask feature is built in
`ifdef VLANE_SEQ_MASK_EN
      mask_exp = 16'hF0F0;
`else
      mask_exp = 16'hFFFF;
`endif
      issue(5'd0, 5'd0, 5'd0, 2'b10, 2'b00, 8'd4, 1'b0, 128'b1010);
      chk("mask_valid", bus.beat_valid, 1);
      chk("mask_be", bus.beat_be, mask_exp);
      chk("mask_last", bus.beat_last, 1);
      tick();
      chk("mask_done", bus.done, 1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vlane_sequencer.md
# vlane_sequencer

Parametrised vector element-group sequencer between scalar issue and an NLANES-wide vector lane array. Accepts one vector instruction per handshake and strip-mines it into per-cycle beats covering all active elements of the register group. Supports SEW 8/16/32 and LMUL 1/2/4/8. Drives the register indices, beat offset and per-byte write enables, with tail masking and optional v0 masking, consumed by the lane register files and ALUs.

## Interface
- VLEN, 128, vector register width in bits
- ELEN, 32, lane width in bits; power of two, 8..64
- NLANES, 4, number of lanes; power of two
- NVREG, 32, architectural vector registers
- Derived: BEW=NLANES*ELEN/8 byte enables; BPR=VLEN/(NLANES*ELEN) beats per register, power of two, ≥1; RW=$clog2(NVREG); VLW=$clog2(8*VLEN/8)+1
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- issue_valid  in  1  instruction offered
- issue_ready  out  1  sequencer idle, can accept
- issue_vd, issue_vs1, issue_vs2  in  RW  base register of each group
- issue_sew  in  2  00=8, 01=16, 10=32, 11 illegal
- issue_lmul  in  2  00=1, 01=2, 10=4, 11=8
- issue_vl  in  VLW  requested element count
- issue_vm  in  1  1=unmasked, 0=masked by v0
- v0_mask  in  VLEN  mask bits, bit i for element i; sampled at issue
- beat_valid  out  1  beat fields valid
- beat_ready  in  1  lanes accept beat
- beat_vd, beat_vs1, beat_vs2  out  RW  register of this beat
- beat_off  out  max(1,$clog2(BPR))  beat index within register
- beat_be  out  BEW  byte write enables, lane l = bits [l*ELEN/8 +: ELEN/8]
- beat_last  out  1  final beat of instruction
- busy  out  1  instruction in flight
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle rejection pulse

## Operation
- States IDLE, RUN, DONE. issue_ready = (state==IDLE); busy = (state!=IDLE).
- Issue accepted on issue_valid & issue_ready. All issue fields, including v0_mask, are registered. Later changes have no effect.
- Illegal: sew=11, or any base not a multiple of LMUL, or base+LMUL>NVREG. Response: illegal=1 next cycle, stay IDLE, no beats, no done.
- VLMAX=LMUL*VLEN/SEW; vl_eff=min(issue_vl, VLMAX).
- EPB=NLANES*ELEN/SEW elements per beat. Beats=ceil(vl_eff/EPB).
- vl_eff=0 goes IDLE→DONE. Otherwise IDLE→RUN with beat counter b=0.
- Beat b fields:
  - beat_vd = vd + b/BPR; beat_vs1 and beat_vs2 are formed the same way.
  - beat_off = b%BPR.
  - beat_last = (b==Beats-1).
- Element k of beat b has global index g=b*EPB+k and occupies bytes [k*SEW/8 +: SEW/8]. Those bytes are enabled iff g<vl_eff, and also v0 bit g=1 when masking is active.
- RUN: beat_valid=1. On beat_ready, b increments. If beat_last, RUN→DONE.
- DONE: done=1 for one cycle, then IDLE.

## Timing
- Issue accepted at edge N: beat 0 valid in cycle N+1.
- One beat per cycle while beat_ready=1. Beat k+1 is valid the cycle after beat k is accepted.
- While beat_valid & !beat_ready, all beat_* outputs are held stable.
- done is asserted in the cycle after the last beat is accepted. issue_ready reasserts the cycle after done.
- For vl_eff=0, done is asserted in cycle N+1.
- Minimum latency from issue to next issue_ready: Beats+2 cycles.
- Reset, applied on any edge with rst_n=0, including mid-instruction:
  - state returns to IDLE and the in-flight group is abandoned with no done.
  - Outputs after the reset edge: issue_ready=1; beat_valid, beat_* fields, busy, done and illegal are all 0.

## Configuration
- VLANE_SEQ_MASK_EN defined: issue_vm=0 gates beat_be with registered v0_mask as described above.
- Undefined: issue_vm and v0_mask are ignored, all instructions are treated as unmasked, and no mask register is synthesised. The port list is the same either way.

## Test plan
All scenarios use the default parameters, so BPR=1 and BEW=16.
- SEW=32, LMUL=1, vl=3, vd=2 → one beat: beat_vd=2, beat_be=0x0FFF, beat_last=1; done in the following cycle.
- SEW=8, LMUL=4, vl=40, vd=4, vs2=8 → three beats:
  - beat_vd 4/5/6 and beat_vs2 8/9/10;
  - beat_be 0xFFFF, 0xFFFF, 0x00FF;
  - beat_last only on the third beat.
- Same instruction as the previous scenario, with beat_ready held low for 3 cycles on beat 1 → beat 1 fields stay constant and beat 2 follows the cycle after acceptance.
- Boundary values:
  - vl=0 → no beat_valid, done one cycle after issue.
  - SEW=32, LMUL=2, vl=200 → clamped to 8: two beats with be=0xFFFF each.
- Rejections and reset:
  - sew=11 → illegal pulse, issue_ready stays 1.
  - LMUL=2 with vd=3 → illegal pulse.
  - rst_n low during beat 1 → next cycle beat_valid=0, issue_ready=1, no done.
- With VLANE_SEQ_MASK_EN: SEW=32, vl=4, vm=0, v0_mask=0b1010 → beat_be=0xF0F0. Without the macro, the same stimulus gives 0xFFFF.
